// File: rtl/cpu_fsm.sv
// Moore control FSM for the simple RISC datapath: decodes opcode/op latched on the
// start strobe and sequences regfile, A/B/C pipeline registers, status register and ALU op.
module cpu_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [3:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] alu_op
);

    // state    | meaning
    // S_WAIT   | idle, w=1, accepts s and latches opcode/op
    // S_DECODE | branch on latched {opcode,op}, no strobes
    // S_GET_A  | read Rn into A
    // S_GET_B  | read Rm into B
    // S_EXEC   | ALU result into C, or status update for CMP
    // S_WR_REG | write C back to Rd
    // S_WR_IMM | write sximm8 to Rn
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] opcode_q;
    logic [1:0] op_q;
    logic [4:0] instr;

    assign instr = {opcode_q, op_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && s) begin
                opcode_q <= opcode;
                op_q     <= op;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        w         = 1'b0;
        nsel      = 3'b000;
        vsel      = 4'b0001;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        alu_op    = 2'b00;
        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (instr)
                    5'b110_10: state_nxt = S_WR_IMM;
                    5'b110_00,
                    5'b101_11: state_nxt = S_GET_B;
                    5'b101_00,
                    5'b101_01,
                    5'b101_10: state_nxt = S_GET_A;
                    default:   state_nxt = S_WAIT;
                endcase
            end
            S_GET_A: begin
                nsel      = 3'b100;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                nsel      = 3'b001;
                loadb     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // MOV Rd,Rm passes Rm through the adder with A forced to zero
                if (instr == 5'b110_00) begin
                    asel   = 1'b1;
                    alu_op = 2'b00;
                end else begin
                    alu_op = op_q;
                end
                if (instr == 5'b101_01) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WR_REG;
                end
            end
            S_WR_REG: begin
                nsel      = 3'b010;
                vsel      = 4'b0001;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WR_IMM: begin
                nsel      = 3'b100;
                vsel      = 4'b0100;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

endmodule
